fifo_out_packer: RTL

//  Consumer stage directly downstream of the FIFO read port.
//  - Drains 16-bit words via data_out / data_out_vld / data_out_rdy.
//  - Packs RATIO consecutive words into one wide beat and presents it on a registered valid/ready output.
//  - flush closes a partial beat early; pack_keep marks which lanes are valid.

---
 rtl/fifo_out_pack_pkg.sv | 16 +
 rtl/fifo_out_packer_if.sv | 24 ++
 rtl/fifo_out_pack_obuf.sv | 40 ++++
 rtl/fifo_out_packer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fifo_out_pack_pkg.sv
// Shared types, defaults and lane-mask helper for the FIFO output packer.
package fifo_out_pack_pkg;

  typedef enum logic {FILL, FLUSH} pack_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int RATIO_DEF  = 2;

  // Valid-lane mask for a beat holding cnt words; RATIO never exceeds 8.
  function automatic logic [7:0] keep_mask(input int cnt);
    logic [15:0] m;
    m = (16'd1 << cnt) - 16'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/fifo_out_packer_if.sv
// Word input and packed-beat output of the FIFO output packer; slave is the packer side.
interface fifo_out_packer_if #(
  parameter int DATA_W = 16,
  parameter int RATIO  = 2
);
  logic [DATA_W-1:0]       data_out;
  logic                    data_out_vld;
  logic                    data_out_rdy;
  logic                    flush;
  logic [DATA_W*RATIO-1:0] pack_data;
  logic [RATIO-1:0]        pack_keep;
  logic                    pack_vld;
  logic                    pack_rdy;

  modport slave (
    input  data_out, data_out_vld, flush, pack_rdy,
    output data_out_rdy, pack_data, pack_keep, pack_vld
  );

  modport master (
    output data_out, data_out_vld, flush, pack_rdy,
    input  data_out_rdy, pack_data, pack_keep, pack_vld
  );
endinterface

// File: rtl/fifo_out_pack_obuf.sv
// Single-entry output register: load wins over take, so a new beat can replace the one being taken.
// Latency 1 from load_i; vld_o/data_o/keep_o hold until rdy_i.
module fifo_out_pack_obuf #(
  parameter int DATA_W = 16,
  parameter int RATIO  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [DATA_W*RATIO-1:0] data_i,
  input  logic [RATIO-1:0]        keep_i,
  input  logic                    rdy_i,
  output logic                    vld_o,
  output logic [DATA_W*RATIO-1:0] data_o,
  output logic [RATIO-1:0]        keep_o,
  output logic                    full_o
);
  logic                    vld_q;
  logic [DATA_W*RATIO-1:0] data_q;
  logic [RATIO-1:0]        keep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      keep_q <= keep_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign keep_o = keep_q;
  assign full_o = vld_q;
endmodule

// File: rtl/fifo_out_packer.sv
// Packs RATIO FIFO words into one beat (latency 1); flush closes a partial beat. Input stalls only
// when a completing word or pending flush has nowhere to go. Optional counters: FIFO_OUT_PACK_STATS_EN.
module fifo_out_packer
  import fifo_out_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RATIO  = RATIO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fifo_out_packer_if.slave bus
`ifdef FIFO_OUT_PACK_STATS_EN
  ,
  output logic [31:0]      stat_words,
  output logic [15:0]      stat_flushes
`endif
);
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  typedef logic [RATIO-1:0][DATA_W-1:0] acc_t;

  acc_t             acc_q, acc_d, merged;
  logic [CNT_W-1:0] cnt_q, cnt_d, fill_cnt;
  pack_state_e      state_q, state_d;
  logic             obuf_full, obuf_free, accept, complete;
  logic             load, partial_load;
  logic [RATIO-1:0] load_keep;

  assign obuf_free = !obuf_full || bus.pack_rdy;
  assign bus.data_out_rdy = !rst && (state_q == FILL) &&
                            !((cnt_q == LAST) && obuf_full && !bus.pack_rdy);
  assign accept   = bus.data_out_vld && bus.data_out_rdy;
  assign complete = accept && (cnt_q == LAST);

  always_comb begin
    merged = acc_q;
    if (accept) merged[cnt_q] = bus.data_out;
    fill_cnt     = accept ? cnt_q + CNT_W'(1) : cnt_q;
    acc_d        = merged;
    cnt_d        = fill_cnt;
    state_d      = state_q;
    load         = 1'b0;
    partial_load = 1'b0;
    load_keep    = '1;
    case (state_q)
      FILL: begin
        if (complete) begin
          load  = 1'b1;
          cnt_d = '0;
          acc_d = '0;
        end else if (bus.flush && (fill_cnt != '0)) begin
          // Flush sees the word accepted this cycle; a busy output parks the partial beat.
          if (obuf_free) begin
            load         = 1'b1;
            partial_load = 1'b1;
            load_keep    = RATIO'(keep_mask(int'(fill_cnt)));
            cnt_d        = '0;
            acc_d        = '0;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (obuf_free) begin
          load         = 1'b1;
          partial_load = 1'b1;
          load_keep    = RATIO'(keep_mask(int'(cnt_q)));
          cnt_d        = '0;
          acc_d        = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= FILL;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  fifo_out_pack_obuf #(
    .DATA_W (DATA_W),
    .RATIO  (RATIO)
  ) u_obuf (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (merged),
    .keep_i (load_keep),
    .rdy_i  (bus.pack_rdy),
    .vld_o  (bus.pack_vld),
    .data_o (bus.pack_data),
    .keep_o (bus.pack_keep),
    .full_o (obuf_full)
  );

`ifdef FIFO_OUT_PACK_STATS_EN
  logic [31:0] stat_words_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q   <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (accept)       stat_words_q   <= stat_words_q + 32'd1;
      if (partial_load) stat_flushes_q <= stat_flushes_q + 16'd1;
    end
  end

  assign stat_words   = stat_words_q;
  assign stat_flushes = stat_flushes_q;
`endif
endmodule
